csr_file: RTL and testbench

- Machine-mode CSR register file for the Mini-RISC-V core.
- Responds to the CSR control bundle the decode stage issues (csrsel, csrread, csrwrite) and performs CSRRW/S/C and their immediate forms.
- Maintains the cycle and instret counters.
- Captures trap state on illegal instructions and restores it on mret.
- Located in the execute stage, beside the ALU.

---
 rtl/csr_if.sv | 30 +++
 rtl/csr_file.sv | 162 ++++++++++++++++
 tb/tb_csr_file.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_if.sv
// CSR control and data bundle between the execute stage and the CSR file.
interface csr_if;
  logic [2:0]  csrsel;
  logic        csrread;
  logic        csrwrite;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  zimm;
  logic        instret;
  logic        illegal_ins;
  logic [31:0] trap_pc;
  logic        mret;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_taken;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;

  modport master (
    output csrsel, csrread, csrwrite, csr_addr, rs1_data, zimm,
           instret, illegal_ins, trap_pc, mret,
    input  csr_rdata, csr_illegal, trap_taken, trap_vector, mepc_out
  );

  modport slave (
    input  csrsel, csrread, csrwrite, csr_addr, rs1_data, zimm,
           instret, illegal_ins, trap_pc, mret,
    output csr_rdata, csr_illegal, trap_taken, trap_vector, mepc_out
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSRRW/S/C(+I), 64-bit cycle/instret counters,
// trap capture on illegal instructions and restore on mret.
module csr_file #(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_1100
) (
  input  logic   clk,
  input  logic   rst_n,
  csr_if.slave   bus
);

  localparam logic [11:0] AddrMstatus   = 12'h300;
  localparam logic [11:0] AddrMisa      = 12'h301;
  localparam logic [11:0] AddrMtvec     = 12'h305;
  localparam logic [11:0] AddrMscratch  = 12'h340;
  localparam logic [11:0] AddrMepc      = 12'h341;
  localparam logic [11:0] AddrMcause    = 12'h342;
  localparam logic [11:0] AddrMtval     = 12'h343;
  localparam logic [11:0] AddrMcycle    = 12'hB00;
  localparam logic [11:0] AddrMinstret  = 12'hB02;
  localparam logic [11:0] AddrMcycleh   = 12'hB80;
  localparam logic [11:0] AddrMinstreth = 12'hB82;
  localparam logic [11:0] AddrCycle     = 12'hC00;
  localparam logic [11:0] AddrInstret   = 12'hC02;
  localparam logic [11:0] AddrCycleh    = 12'hC80;
  localparam logic [11:0] AddrInstreth  = 12'hC82;
  localparam logic [11:0] AddrMhartid   = 12'hF14;

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;

  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] src_val;
  logic [XLEN-1:0] new_val;
  logic            implemented;
  logic            access_illegal;
  logic            commit;

  // MPP is hard-wired to machine mode; only MIE and MPIE are real state.
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

  // Address decode: current (pre-write) value and whether the CSR exists.
  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    case (bus.csr_addr)
      AddrMstatus:                 old_val = mstatus_val;
      AddrMisa:                    old_val = MISA_VALUE;
      AddrMtvec:                   old_val = mtvec_q;
      AddrMscratch:                old_val = mscratch_q;
      AddrMepc:                    old_val = mepc_q;
      AddrMcause:                  old_val = mcause_q;
      AddrMtval:                   old_val = mtval_q;
      AddrMcycle,   AddrCycle:     old_val = mcycle_q[31:0];
      AddrMcycleh,  AddrCycleh:    old_val = mcycle_q[63:32];
      AddrMinstret, AddrInstret:   old_val = minstret_q[31:0];
      AddrMinstreth, AddrInstreth: old_val = minstret_q[63:32];
      AddrMhartid:                 old_val = '0;
      default:                     implemented = 1'b0;
    endcase
  end

  // Operand selection and the W/S/C read-modify-write result.
  always_comb begin
    src_val = bus.csrsel[2] ? {27'b0, bus.zimm} : bus.rs1_data;
    case (bus.csrsel[1:0])
      2'b01:   new_val = src_val;
      2'b10:   new_val = old_val | src_val;
      2'b11:   new_val = old_val & ~src_val;
      default: new_val = old_val;
    endcase
  end

  assign access_illegal = ((bus.csrread | bus.csrwrite) & ~implemented) |
                          (bus.csrwrite & (bus.csr_addr[11:10] == 2'b11));
  assign commit = bus.csrwrite & ~access_illegal & ~bus.illegal_ins &
                  (bus.csrsel[1:0] != 2'b00);

  // Next-state: counters tick, a committed write replaces one CSR (or one
  // counter half, freezing the other half), then trap/mret update mstatus.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = bus.instret ? minstret_q + 64'd1 : minstret_q;
    if (commit) begin
      case (bus.csr_addr)
        AddrMstatus: begin
          mie_d  = new_val[3];
          mpie_d = new_val[7];
        end
        AddrMtvec:     mtvec_d    = {new_val[31:2], 2'b00};
        AddrMscratch:  mscratch_d = new_val;
        AddrMepc:      mepc_d     = {new_val[31:2], 2'b00};
        AddrMcause:    mcause_d   = new_val;
        AddrMtval:     mtval_d    = new_val;
        AddrMcycle:    mcycle_d   = {mcycle_q[63:32], new_val};
        AddrMcycleh:   mcycle_d   = {new_val, mcycle_q[31:0]};
        AddrMinstret:  minstret_d = {minstret_q[63:32], new_val};
        AddrMinstreth: minstret_d = {new_val, minstret_q[31:0]};
        default: ;
      endcase
    end
    if (bus.illegal_ins) begin
      mepc_d   = {bus.trap_pc[31:2], 2'b00};
      mcause_d = 32'd2;
      mtval_d  = '0;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (bus.mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign bus.csr_rdata   = (rst_n && bus.csrread && implemented) ? old_val : '0;
  assign bus.csr_illegal = rst_n & access_illegal;
  assign bus.trap_taken  = rst_n & bus.illegal_ins;
  assign bus.trap_vector = {mtvec_q[31:2], 2'b00};
  assign bus.mepc_out    = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed table, hand sequences for
// counters/traps/reset, and randomized traffic against a reference model.
module tb_csr_file;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0000;
  localparam logic [31:0] MISA_VAL  = 32'h4000_1100;

  typedef struct {
    string       name;
    logic [2:0]  sel;
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [4:0]  zimm;
    logic [31:0] expRdata;
    logic        expIllegal;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checkCount = 0;
  int   errCount = 0;

  logic        mMie, mMpie;
  logic [31:0] mMtvec, mMscratch, mMepc, mMcause, mMtval;
  logic [63:0] mCycle, mInstret;

  csr_if bus();

  csr_file #(.XLEN(32), .MTVEC_RESET(MTVEC_RST), .MISA_VALUE(MISA_VAL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] sel, input logic rd, input logic wr,
                               input logic [11:0] addr, input logic [31:0] rs1,
                               input logic [4:0] zimm, input logic instr,
                               input logic illIns, input logic [31:0] trapPc,
                               input logic mretIn);
    bus.csrsel      = sel;
    bus.csrread     = rd;
    bus.csrwrite    = wr;
    bus.csr_addr    = addr;
    bus.rs1_data    = rs1;
    bus.zimm        = zimm;
    bus.instret     = instr;
    bus.illegal_ins = illIns;
    bus.trap_pc     = trapPc;
    bus.mret        = mretIn;
  endtask

  task automatic csrOp(input logic [2:0] sel, input logic rd, input logic wr,
                       input logic [11:0] addr, input logic [31:0] rs1, input logic [4:0] zimm);
    applyStimulus(sel, rd, wr, addr, rs1, zimm, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic modelReset();
    mMie = 1'b0; mMpie = 1'b0;
    mMtvec = MTVEC_RST & ~32'd3;
    mMscratch = '0; mMepc = '0; mMcause = '0; mMtval = '0;
    mCycle = '0; mInstret = '0;
  endtask

  // Architectural view of a CSR read.
  task automatic modelRead(input logic [11:0] a, output bit ok, output logic [31:0] v);
    ok = 1'b1;
    v  = '0;
    case (a)
      12'h300: v = 32'h0000_1800 + (mMie ? 32'd8 : 32'd0) + (mMpie ? 32'd128 : 32'd0);
      12'h301: v = MISA_VAL;
      12'h305: v = mMtvec;
      12'h340: v = mMscratch;
      12'h341: v = mMepc;
      12'h342: v = mMcause;
      12'h343: v = mMtval;
      12'hB00, 12'hC00: v = mCycle[31:0];
      12'hB80, 12'hC80: v = mCycle[63:32];
      12'hB02, 12'hC02: v = mInstret[31:0];
      12'hB82, 12'hC82: v = mInstret[63:32];
      12'hF14: v = 32'h0;
      default: ok = 1'b0;
    endcase
  endtask

  task automatic compareModel();
    bit ok;
    logic [31:0] old;
    logic illegalAcc;
    modelRead(bus.csr_addr, ok, old);
    illegalAcc = ((bus.csrread || bus.csrwrite) && !ok) ||
                 (bus.csrwrite && (bus.csr_addr >= 12'hC00));
    checkOutput("model_rdata", {32'h0, bus.csr_rdata}, {32'h0, (bus.csrread && ok) ? old : 32'h0});
    checkOutput("model_illegal", {63'h0, bus.csr_illegal}, {63'h0, illegalAcc});
    checkOutput("model_trap_taken", {63'h0, bus.trap_taken}, {63'h0, bus.illegal_ins});
    checkOutput("model_trap_vector", {32'h0, bus.trap_vector}, {32'h0, mMtvec & ~32'd3});
    checkOutput("model_mepc_out", {32'h0, bus.mepc_out}, {32'h0, mMepc});
  endtask

  task automatic modelUpdate();
    bit ok;
    logic [31:0] old, src, nv;
    logic illegalAcc, commit;
    logic [63:0] nCycle, nInstret;
    modelRead(bus.csr_addr, ok, old);
    illegalAcc = ((bus.csrread || bus.csrwrite) && !ok) ||
                 (bus.csrwrite && (bus.csr_addr >= 12'hC00));
    commit = bus.csrwrite && !illegalAcc && !bus.illegal_ins && (bus.csrsel[1:0] != 2'b00);
    src = bus.csrsel[2] ? 32'(bus.zimm) : bus.rs1_data;
    case (bus.csrsel[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      2'b11:   nv = old & ~src;
      default: nv = old;
    endcase
    nCycle   = mCycle + 64'd1;
    nInstret = mInstret + (bus.instret ? 64'd1 : 64'd0);
    if (commit) begin
      case (bus.csr_addr)
        12'h300: begin mMie = nv[3]; mMpie = nv[7]; end
        12'h305: mMtvec = nv & ~32'd3;
        12'h340: mMscratch = nv;
        12'h341: mMepc = nv & ~32'd3;
        12'h342: mMcause = nv;
        12'h343: mMtval = nv;
        12'hB00: nCycle   = {mCycle[63:32], nv};
        12'hB80: nCycle   = {nv, mCycle[31:0]};
        12'hB02: nInstret = {mInstret[63:32], nv};
        12'hB82: nInstret = {nv, mInstret[31:0]};
        default: ;
      endcase
    end
    mCycle   = nCycle;
    mInstret = nInstret;
    if (bus.illegal_ins) begin
      mMepc = bus.trap_pc & ~32'd3;
      mMcause = 32'd2;
      mMtval = 32'd0;
      mMpie = mMie;
      mMie = 1'b0;
    end else if (bus.mret) begin
      mMie = mMpie;
      mMpie = 1'b1;
    end
  endtask

  task automatic tick();
    compareModel();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  // Apply a read, compare against a constant, advance one cycle.
  task automatic readExpect(input string name, input logic [11:0] addr, input logic [31:0] exp);
    csrOp(3'b000, 1'b1, 1'b0, addr, 32'h0, 5'h0);
    #1;
    checkOutput(name, {32'h0, bus.csr_rdata}, {32'h0, exp});
    tick();
  endtask

  vec_t vecs[$];
  logic [11:0] addrList [0:19];

  initial begin
    logic [31:0] a, b;

    vecs.push_back('{"rw_mscratch",     3'b001, 1, 1, 12'h340, 32'hDEAD_BEEF, 5'h00, 32'h0000_0000, 0});
    vecs.push_back('{"rs_mscratch",     3'b010, 1, 1, 12'h340, 32'h0000_0010, 5'h00, 32'hDEAD_BEEF, 0});
    vecs.push_back('{"rd_after_set",    3'b010, 1, 0, 12'h340, 32'h0000_0000, 5'h00, 32'hDEAD_BEFF, 0});
    vecs.push_back('{"rci_mscratch",    3'b111, 1, 1, 12'h340, 32'h0000_0000, 5'h1F, 32'hDEAD_BEFF, 0});
    vecs.push_back('{"rd_after_clr",    3'b000, 1, 0, 12'h340, 32'h0000_0000, 5'h00, 32'hDEAD_BEE0, 0});
    vecs.push_back('{"rd_misa",         3'b000, 1, 0, 12'h301, 32'h0000_0000, 5'h00, 32'h4000_1100, 0});
    vecs.push_back('{"rd_mstatus",      3'b000, 1, 0, 12'h300, 32'h0000_0000, 5'h00, 32'h0000_1800, 0});
    vecs.push_back('{"rd_mhartid",      3'b000, 1, 0, 12'hF14, 32'h0000_0000, 5'h00, 32'h0000_0000, 0});
    vecs.push_back('{"rd_unimpl_7c0",   3'b000, 1, 0, 12'h7C0, 32'h0000_0000, 5'h00, 32'h0000_0000, 1});
    vecs.push_back('{"wr_cycle_ro",     3'b001, 0, 1, 12'hC00, 32'h0000_1234, 5'h00, 32'h0000_0000, 1});
    vecs.push_back('{"rsi_mtval",       3'b110, 1, 1, 12'h343, 32'h0000_0000, 5'h05, 32'h0000_0000, 0});
    vecs.push_back('{"rd_mtval",        3'b000, 1, 0, 12'h343, 32'h0000_0000, 5'h00, 32'h0000_0005, 0});
    vecs.push_back('{"wr_mepc_unalign", 3'b001, 0, 1, 12'h341, 32'h0000_0103, 5'h00, 32'h0000_0000, 0});
    vecs.push_back('{"rd_mepc",         3'b000, 1, 0, 12'h341, 32'h0000_0000, 5'h00, 32'h0000_0100, 0});
    vecs.push_back('{"rd_mtvec",        3'b000, 1, 0, 12'h305, 32'h0000_0000, 5'h00, 32'h0000_0000, 0});
    vecs.push_back('{"sel00_nowrite",   3'b000, 1, 1, 12'h340, 32'hFFFF_FFFF, 5'h00, 32'hDEAD_BEE0, 0});
    vecs.push_back('{"rd_after_sel00",  3'b000, 1, 0, 12'h340, 32'h0000_0000, 5'h00, 32'hDEAD_BEE0, 0});
    vecs.push_back('{"wr_unimpl_7c0",   3'b001, 0, 1, 12'h7C0, 32'h0000_0001, 5'h00, 32'h0000_0000, 1});

    addrList = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                 12'hC82, 12'hF14, 12'h7C0, 12'h123, 12'hB00, 12'h340};

    // Reset held: outputs must be quiet even with active inputs.
    rst_n = 1'b0;
    applyStimulus(3'b001, 1'b1, 1'b1, 12'h300, 32'h0, 5'h0, 1'b0, 1'b1, 32'h100, 1'b0);
    #1;
    checkOutput("rst_rdata", {32'h0, bus.csr_rdata}, 64'h0);
    checkOutput("rst_illegal", {63'h0, bus.csr_illegal}, 64'h0);
    checkOutput("rst_trap_taken", {63'h0, bus.trap_taken}, 64'h0);
    checkOutput("rst_mepc_out", {32'h0, bus.mepc_out}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();

    // mcycle counts one per cycle from zero after reset release.
    csrOp(3'b000, 1'b1, 1'b0, 12'hB00, 32'h0, 5'h0);
    #1;
    a = bus.csr_rdata;
    checkOutput("mcycle_first", {32'h0, a}, 64'h0);
    tick();
    repeat (3) begin
      csrOp(3'b000, 1'b0, 1'b0, 12'h000, 32'h0, 5'h0);
      #1;
      tick();
    end
    csrOp(3'b000, 1'b1, 1'b0, 12'hB00, 32'h0, 5'h0);
    #1;
    b = bus.csr_rdata;
    checkOutput("mcycle_delta", {32'h0, b - a}, 64'd4);
    tick();

    // Directed table.
    foreach (vecs[i]) begin
      csrOp(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].rs1, vecs[i].zimm);
      #1;
      checkOutput({vecs[i].name, "_rdata"}, {32'h0, bus.csr_rdata}, {32'h0, vecs[i].expRdata});
      checkOutput({vecs[i].name, "_illegal"}, {63'h0, bus.csr_illegal}, {63'h0, vecs[i].expIllegal});
      tick();
    end

    // Low half written near wrap, high half written next, then carry propagates.
    csrOp(3'b001, 1'b0, 1'b1, 12'hB00, 32'hFFFF_FFFF, 5'h0); #1; tick();
    csrOp(3'b001, 1'b0, 1'b1, 12'hB80, 32'h0000_0000, 5'h0); #1; tick();
    csrOp(3'b000, 1'b0, 1'b0, 12'h000, 32'h0, 5'h0); #1; tick();
    readExpect("mcycleh_after_wrap", 12'hB80, 32'h1);
    readExpect("cycleh_alias", 12'hC80, 32'h1);
    csrOp(3'b001, 1'b0, 1'b1, 12'hC80, 32'h0000_0077, 5'h0);
    #1;
    checkOutput("wr_cycleh_illegal", {63'h0, bus.csr_illegal}, 64'h1);
    tick();
    readExpect("cycleh_unchanged", 12'hC80, 32'h1);

    // Trap entry with MIE set and a misaligned mtvec.
    csrOp(3'b001, 1'b0, 1'b1, 12'h300, 32'h0000_0008, 5'h0); #1; tick();
    csrOp(3'b001, 1'b0, 1'b1, 12'h305, 32'h0000_0203, 5'h0); #1; tick();
    readExpect("mstatus_mie_set", 12'h300, 32'h0000_1808);
    applyStimulus(3'b001, 1'b0, 1'b1, 12'h340, 32'h0000_0055, 5'h0, 1'b0, 1'b1, 32'h0000_0106, 1'b0);
    #1;
    checkOutput("trap_taken", {63'h0, bus.trap_taken}, 64'h1);
    checkOutput("trap_vector", {32'h0, bus.trap_vector}, 64'h200);
    tick();
    readExpect("trap_mepc", 12'h341, 32'h0000_0104);
    readExpect("trap_mcause", 12'h342, 32'h2);
    readExpect("trap_mstatus", 12'h300, 32'h0000_1880);
    readExpect("trap_mtval", 12'h343, 32'h0);
    readExpect("trap_write_suppressed", 12'h340, 32'hDEAD_BEE0);

    // mret restores MIE from MPIE.
    applyStimulus(3'b000, 1'b0, 1'b0, 12'h000, 32'h0, 5'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("mret_mepc_out", {32'h0, bus.mepc_out}, 64'h104);
    tick();
    readExpect("mret_mstatus", 12'h300, 32'h0000_1888);

    // Trap and mret together: trap wins.
    applyStimulus(3'b000, 1'b0, 1'b0, 12'h000, 32'h0, 5'h0, 1'b0, 1'b1, 32'h0000_0243, 1'b1);
    #1;
    tick();
    readExpect("trap_mret_mstatus", 12'h300, 32'h0000_1880);
    csrOp(3'b000, 1'b0, 1'b0, 12'h000, 32'h0, 5'h0);
    #1;
    checkOutput("trap_mret_mepc_out", {32'h0, bus.mepc_out}, 64'h240);
    tick();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [11:0] ad;
      logic rd, wr, ill, mr;
      ad  = addrList[$urandom_range(0, 19)];
      rd  = 1'($urandom);
      wr  = 1'($urandom);
      if (ad == 12'h301) wr = 1'b0;
      ill = ($urandom_range(0, 11) == 0);
      mr  = !wr && ($urandom_range(0, 9) == 0);
      applyStimulus(3'($urandom), rd, wr, ad, $urandom, 5'($urandom), 1'($urandom),
                    ill, $urandom, mr);
      #1;
      tick();
    end

    // Asynchronous reset mid-cycle discards a pending write.
    readExpect("pre_reset_mscratch_model", 12'h340, mMscratch);
    applyStimulus(3'b001, 1'b1, 1'b1, 12'h340, 32'hA5A5_A5A5, 5'h0, 1'b1, 1'b1, 32'h0000_0310, 1'b0);
    #1;
    checkOutput("pre_reset_trap_taken", {63'h0, bus.trap_taken}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_rdata", {32'h0, bus.csr_rdata}, 64'h0);
    checkOutput("async_rst_trap_taken", {63'h0, bus.trap_taken}, 64'h0);
    checkOutput("async_rst_illegal", {63'h0, bus.csr_illegal}, 64'h0);
    checkOutput("async_rst_mepc_out", {32'h0, bus.mepc_out}, 64'h0);
    checkOutput("async_rst_trap_vector", {32'h0, bus.trap_vector}, {32'h0, MTVEC_RST & ~32'd3});
    @(posedge clk);
    @(negedge clk);
    csrOp(3'b000, 1'b0, 1'b0, 12'h000, 32'h0, 5'h0);
    rst_n = 1'b1;
    modelReset();
    readExpect("post_reset_mscratch", 12'h340, 32'h0);
    readExpect("post_reset_mcycle", 12'hB00, 32'h1);
    readExpect("post_reset_mstatus", 12'h300, 32'h0000_1800);

    $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
    $finish;
  end

endmodule
